mmio_queue_fifo: RTL and testbench

- Parametrised successor to the fixed 64-bit, fixed-depth MMIO shift FIFO that sits behind the AFU user register at h0020.
- Circular-buffer storage with configurable width and depth, plus occupancy and status outputs that the AFU maps to additional MMIO addresses.
- Two modes:
  - DELAY: shift-register compatible; every push ejects the oldest entry once full.
  - QUEUE: true push/pop FIFO with full/empty flags and sticky error flags.

---
 rtl/mmio_fifo_pkg.sv | 22 ++
 rtl/mmio_queue_fifo_if.sv | 31 +++
 rtl/mod_ptr.sv | 28 ++
 rtl/mmio_queue_fifo.sv | 128 ++++++++++++
 tb/tb_mmio_queue_fifo.sv | 168 ++++++++++++++++
 5 files changed

// File: rtl/mmio_fifo_pkg.sv
// Shared definitions for the MMIO queue FIFO: operating modes, register map
// addresses and the status-word layout.
package mmio_fifo_pkg;

  typedef enum logic {
    FIFO_MODE_DELAY = 1'b0,
    FIFO_MODE_QUEUE = 1'b1
  } fifo_mode_e;

  localparam logic [15:0] MMIO_FIFO_DATA_ADDR   = 16'h0020;
  localparam logic [15:0] MMIO_FIFO_STATUS_ADDR = 16'h0022;

  // Status word: count in [15:0]; {underflow, overflow, full, empty} in [19:16].
  function automatic logic [31:0] pack_status(input logic [15:0] cnt,
                                              input logic empty,
                                              input logic full,
                                              input logic overflow,
                                              input logic underflow);
    return {12'h000, underflow, overflow, full, empty, cnt};
  endfunction

endpackage

// File: rtl/mmio_queue_fifo_if.sv
// Handshake/status bundle between the MMIO register block (master) and the
// FIFO (slave).
interface mmio_queue_fifo_if #(
  parameter int WIDTH = 64,
  parameter int DEPTH = 8
);
  localparam int CW = $clog2(DEPTH + 1);

  logic             clr;
  logic             clr_err;
  logic             push;
  logic [WIDTH-1:0] push_data;
  logic             pop;
  logic [WIDTH-1:0] pop_data;
  logic [CW-1:0]    count;
  logic             empty;
  logic             full;
  logic             almost_full;
  logic             overflow;
  logic             underflow;

  modport master (
    output clr, clr_err, push, push_data, pop,
    input  pop_data, count, empty, full, almost_full, overflow, underflow
  );

  modport slave (
    input  clr, clr_err, push, push_data, pop,
    output pop_data, count, empty, full, almost_full, overflow, underflow
  );
endinterface

// File: rtl/mod_ptr.sv
// Pointer counter over 0..MAX with an explicit wrap, so non-power-of-two
// ranges work without relying on truncation.
module mod_ptr #(
  parameter int MAX = 7,
  parameter int W   = $clog2(MAX + 1)
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         clr,
  input  logic         inc,
  output logic [W-1:0] ptr
);
  localparam logic [W-1:0] LAST = W'(MAX);

  logic [W-1:0] ptr_reg;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ptr_reg <= '0;
    end else if (clr) begin
      ptr_reg <= '0;
    end else if (inc) begin
      ptr_reg <= (ptr_reg == LAST) ? '0 : ptr_reg + W'(1);
    end
  end

  assign ptr = ptr_reg;
endmodule

// File: rtl/mmio_queue_fifo.sv
// Circular-buffer FIFO behind the AFU user register; DELAY mode mimics the
// legacy shift FIFO, QUEUE mode is a push/pop FIFO with sticky error flags.
module mmio_queue_fifo
  import mmio_fifo_pkg::*;
#(
  parameter int WIDTH        = 64,
  parameter int DEPTH        = 8,
  parameter int MODE         = 0,
  parameter int AFULL_THRESH = DEPTH - 1
) (
  input  logic                  clk,
  input  logic                  rst,
  mmio_queue_fifo_if.slave      bus
);
  localparam int CW = $clog2(DEPTH + 1);
  localparam int PW = $clog2(DEPTH);
  localparam bit IS_QUEUE = (MODE == int'(FIFO_MODE_QUEUE));

  logic [WIDTH-1:0] mem_reg [DEPTH];
  logic [DEPTH-1:0] wr_en;
  logic [PW-1:0]    wr_ptr;
  logic [PW-1:0]    rd_ptr;

  logic [CW-1:0] count_reg, count_next;
  logic          empty_reg, full_reg, afull_reg;
  logic          overflow_reg, overflow_next;
  logic          underflow_reg, underflow_next;

  logic at_full, at_empty;
  logic push_acc, pop_acc, ovf_evt, udf_evt;

  assign at_full  = (count_reg == CW'(DEPTH));
  assign at_empty = (count_reg == '0);

  always_comb begin
    push_acc = 1'b0;
    pop_acc  = 1'b0;
    ovf_evt  = 1'b0;
    udf_evt  = 1'b0;
    if (!bus.clr) begin
      if (IS_QUEUE) begin
        pop_acc  = bus.pop && !at_empty;
        push_acc = bus.push && (!at_full || bus.pop);
        ovf_evt  = bus.push && !push_acc;
        udf_evt  = bus.pop && at_empty;
      end else begin
        // A push into a full delay line retires the oldest entry.
        push_acc = bus.push;
        pop_acc  = bus.push && at_full;
      end
    end
  end

  always_comb begin
    count_next = count_reg;
    if (bus.clr) begin
      count_next = '0;
    end else begin
      case ({push_acc, pop_acc})
        2'b10:   count_next = count_reg + CW'(1);
        2'b01:   count_next = count_reg - CW'(1);
        default: count_next = count_reg;
      endcase
    end
    // A fresh error in the same cycle as clr_err wins.
    overflow_next  = ovf_evt | (overflow_reg  & ~bus.clr_err);
    underflow_next = udf_evt | (underflow_reg & ~bus.clr_err);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count_reg     <= '0;
      empty_reg     <= 1'b1;
      full_reg      <= 1'b0;
      afull_reg     <= 1'b0;
      overflow_reg  <= 1'b0;
      underflow_reg <= 1'b0;
    end else begin
      count_reg     <= count_next;
      empty_reg     <= (count_next == '0);
      full_reg      <= (count_next == CW'(DEPTH));
      afull_reg     <= (count_next >= CW'(AFULL_THRESH));
      overflow_reg  <= overflow_next;
      underflow_reg <= underflow_next;
    end
  end

  mod_ptr #(.MAX(DEPTH - 1)) u_wr_ptr (
    .clk (clk),
    .rst (rst),
    .clr (bus.clr),
    .inc (push_acc),
    .ptr (wr_ptr)
  );

  mod_ptr #(.MAX(DEPTH - 1)) u_rd_ptr (
    .clk (clk),
    .rst (rst),
    .clr (bus.clr),
    .inc (pop_acc),
    .ptr (rd_ptr)
  );

  for (genvar gi = 0; gi < DEPTH; gi++) begin : g_wr_en
    assign wr_en[gi] = push_acc && (wr_ptr == PW'(gi));
  end

  // Storage carries a reset so a flushed or reset FIFO reads back zeros.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) mem_reg[i] <= '0;
    end else if (bus.clr) begin
      for (int i = 0; i < DEPTH; i++) mem_reg[i] <= '0;
    end else begin
      for (int i = 0; i < DEPTH; i++) begin
        if (wr_en[i]) mem_reg[i] <= bus.push_data;
      end
    end
  end

  assign bus.pop_data    = mem_reg[rd_ptr];
  assign bus.count       = count_reg;
  assign bus.empty       = empty_reg;
  assign bus.full        = full_reg;
  assign bus.almost_full = afull_reg;
  assign bus.overflow    = overflow_reg;
  assign bus.underflow   = underflow_reg;
endmodule

// File: tb/tb_mmio_queue_fifo.sv
// Directed bench: a DELAY instance (64x8) and a QUEUE instance (16x5) checked
// against scoreboards of expected head values and flags.
module tb_mmio_queue_fifo;
  import mmio_fifo_pkg::*;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  mmio_queue_fifo_if #(.WIDTH(64), .DEPTH(8)) di ();
  mmio_queue_fifo_if #(.WIDTH(16), .DEPTH(5)) qi ();

  mmio_queue_fifo #(.WIDTH(64), .DEPTH(8), .MODE(0), .AFULL_THRESH(7)) u_delay (
    .clk (clk),
    .rst (rst),
    .bus (di)
  );

  mmio_queue_fifo #(.WIDTH(16), .DEPTH(5), .MODE(1), .AFULL_THRESH(4)) u_queue (
    .clk (clk),
    .rst (rst),
    .bus (qi)
  );

  int n_vec = 0;
  int n_err = 0;

  logic [63:0] dsb[$];
  logic [15:0] qsb[$];
  bit exp_ovf = 1'b0;
  bit exp_udf = 1'b0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic dstep(input bit p, input logic [63:0] d, input bit po);
    di.push = p; di.push_data = d; di.pop = po;
    if (p) begin
      dsb.push_back(d);
      if (dsb.size() > 8) void'(dsb.pop_front());
    end
    @(posedge clk); #1;
    di.push = 1'b0; di.pop = 1'b0;
    $display("delay push=%0d data=%0h pop=%0d -> count=%0d head=%0h full=%0d",
             p, d, po, di.count, di.pop_data, di.full);
    chk("d_count", 64'(di.count), 64'(dsb.size()));
    chk("d_head", di.pop_data, dsb[0]);
    chk("d_full", 64'(di.full), 64'(dsb.size() == 8));
    chk("d_ovf_udf", 64'({di.overflow, di.underflow}), 64'(0));
  endtask

  task automatic qstep(input bit p, input logic [15:0] d, input bit po,
                       input bit c, input bit ce);
    bit was_full, was_empty, push_ok, pop_ok, ovf_new, udf_new;
    was_full  = (qsb.size() == 5);
    was_empty = (qsb.size() == 0);
    ovf_new = 1'b0;
    udf_new = 1'b0;
    if (c) begin
      qsb.delete();
    end else begin
      pop_ok  = po && !was_empty;
      push_ok = p && (!was_full || po);
      if (pop_ok) void'(qsb.pop_front());
      if (push_ok) qsb.push_back(d);
      ovf_new = p && !push_ok;
      udf_new = po && was_empty;
    end
    exp_ovf = ovf_new | (exp_ovf & ~ce);
    exp_udf = udf_new | (exp_udf & ~ce);
    qi.push = p; qi.push_data = d; qi.pop = po; qi.clr = c; qi.clr_err = ce;
    @(posedge clk); #1;
    qi.push = 1'b0; qi.pop = 1'b0; qi.clr = 1'b0; qi.clr_err = 1'b0;
    $display("queue push=%0d data=%0h pop=%0d clr=%0d clr_err=%0d -> count=%0d head=%0h ovf=%0d udf=%0d",
             p, d, po, c, ce, qi.count, qi.pop_data, qi.overflow, qi.underflow);
    chk("q_count", 64'(qi.count), 64'(qsb.size()));
    chk("q_empty", 64'(qi.empty), 64'(qsb.size() == 0));
    chk("q_full", 64'(qi.full), 64'(qsb.size() == 5));
    chk("q_afull", 64'(qi.almost_full), 64'(qsb.size() >= 4));
    chk("q_ovf", 64'(qi.overflow), 64'(exp_ovf));
    chk("q_udf", 64'(qi.underflow), 64'(exp_udf));
    if (qsb.size() != 0) chk("q_head", 64'(qi.pop_data), 64'(qsb[0]));
  endtask

  initial begin
    di.clr = 1'b0; di.clr_err = 1'b0; di.push = 1'b0; di.push_data = '0; di.pop = 1'b0;
    qi.clr = 1'b0; qi.clr_err = 1'b0; qi.push = 1'b0; qi.push_data = '0; qi.pop = 1'b0;

    // Reset state
    repeat (2) @(posedge clk);
    #1;
    chk("rst_d_count", 64'(di.count), 64'(0));
    chk("rst_d_flags", 64'({di.empty, di.full, di.almost_full, di.overflow, di.underflow}), 64'(5'b10000));
    chk("rst_d_data", di.pop_data, 64'(0));
    chk("rst_q_flags", 64'({qi.empty, qi.full, qi.almost_full, qi.overflow, qi.underflow}), 64'(5'b10000));
    rst = 1'b0;
    @(posedge clk); #1;

    // DELAY: push 1..10, head lags by eight pushes once full
    for (int k = 1; k <= 10; k++) dstep(1'b1, 64'(k), 1'b0);
    chk("d_after10_head", di.pop_data, 64'd3);
    chk("d_after10_count", 64'(di.count), 64'd8);
    dstep(1'b0, 64'h0, 1'b1);  // pop is ignored in DELAY mode

    // QUEUE: fill, drain three, refill across the wrap point
    for (int k = 0; k < 5; k++) qstep(1'b1, 16'h0011 + 16'(k), 1'b0, 1'b0, 1'b0);
    for (int k = 0; k < 3; k++) qstep(1'b0, 16'h0, 1'b1, 1'b0, 1'b0);
    for (int k = 0; k < 3; k++) qstep(1'b1, 16'h0021 + 16'(k), 1'b0, 1'b0, 1'b0);
    chk("q_wrap_count", 64'(qi.count), 64'd5);
    chk("q_wrap_full", 64'(qi.full), 64'd1);
    chk("q_wrap_head", 64'(qi.pop_data), 64'h0014);

    // Full: push+pop together is accepted, push alone overflows
    qstep(1'b1, 16'h0031, 1'b1, 1'b0, 1'b0);
    chk("q_pp_full_ovf", 64'(qi.overflow), 64'd0);
    qstep(1'b1, 16'h0032, 1'b0, 1'b0, 1'b0);
    chk("q_ovf_set", 64'(qi.overflow), 64'd1);
    qstep(1'b0, 16'h0, 1'b0, 1'b0, 1'b0);
    chk("q_ovf_sticky", 64'(qi.overflow), 64'd1);
    qstep(1'b0, 16'h0, 1'b0, 1'b0, 1'b1);
    chk("q_ovf_cleared", 64'(qi.overflow), 64'd0);

    // Drain in order, then underflow on empty
    for (int k = 0; k < 5; k++) qstep(1'b0, 16'h0, 1'b1, 1'b0, 1'b0);
    qstep(1'b0, 16'h0, 1'b1, 1'b0, 1'b0);
    chk("q_udf_set", 64'(qi.underflow), 64'd1);
    qstep(1'b0, 16'h0, 1'b0, 1'b0, 1'b1);
    qstep(1'b1, 16'h0041, 1'b1, 1'b0, 1'b0);  // push+pop on empty: no bypass
    chk("q_pp_empty_count", 64'(qi.count), 64'd1);
    chk("q_pp_empty_udf", 64'(qi.underflow), 64'd1);
    chk("q_pp_empty_head", 64'(qi.pop_data), 64'h0041);

    // clr beats a same-cycle push and leaves sticky flags alone
    qstep(1'b1, 16'h0042, 1'b0, 1'b0, 1'b0);
    qstep(1'b1, 16'h0043, 1'b0, 1'b0, 1'b0);
    qstep(1'b1, 16'h0055, 1'b0, 1'b1, 1'b0);
    chk("q_clr_count", 64'(qi.count), 64'd0);
    chk("q_clr_data", 64'(qi.pop_data), 64'd0);
    chk("q_clr_udf", 64'(qi.underflow), 64'd1);
    qstep(1'b1, 16'h0077, 1'b0, 1'b0, 1'b0);
    chk("q_post_clr_head", 64'(qi.pop_data), 64'h0077);

    // Asynchronous reset mid-stream with five entries loaded
    for (int k = 0; k < 4; k++) qstep(1'b1, 16'h0078 + 16'(k), 1'b0, 1'b0, 1'b0);
    chk("q_pre_rst_count", 64'(qi.count), 64'd5);
    rst = 1'b1;
    #1;
    $display("queue async reset -> count=%0d empty=%0d head=%0h", qi.count, qi.empty, qi.pop_data);
    chk("arst_count", 64'(qi.count), 64'd0);
    chk("arst_empty", 64'(qi.empty), 64'd1);
    chk("arst_data", 64'(qi.pop_data), 64'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    qsb.delete();
    exp_ovf = 1'b0;
    exp_udf = 1'b0;
    qstep(1'b0, 16'h0, 1'b0, 1'b0, 1'b0);
    chk("arst_flags", 64'({qi.full, qi.almost_full, qi.overflow, qi.underflow}), 64'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
